tmds_encoder_hdmi: RTL



---
 rtl/tmds_pkg.sv | 84 ++++++++
 rtl/tmds_channel_hdmi.sv | 108 ++++++++++
 rtl/tmds_encoder_hdmi.sv | 33 +++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared types, symbol tables and helpers for the multi-channel HDMI TMDS encoder.
package tmds_pkg;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned QM_W   = 9;
    localparam int unsigned BIAS_W = 5;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VID_GB = 3'd2,
        MODE_ISLAND = 3'd3,
        MODE_ISL_GB = 3'd4
    } tmds_mode_e;

    localparam logic [SYM_W-1:0] CTRL_SYM_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_SYM_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_SYM_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_SYM_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] GB_SYM_EVEN = 10'b1011001100;
    localparam logic [SYM_W-1:0] GB_SYM_ODD  = 10'b0100110011;

    localparam logic [SYM_W-1:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Payload carried from the transition-minimising stage to the DC-balance stage
    typedef struct packed {
        tmds_mode_e               mode;
        logic [QM_W-1:0]          qm;
        logic signed [BIAS_W-1:0] balance;
        logic [1:0]               ctrl;
        logic [3:0]               terc4;
    } tmds_stage_t;

    function automatic tmds_mode_e mode_decode(input logic [2:0] raw);
        case (raw)
            3'd1:    return MODE_VIDEO;
            3'd2:    return MODE_VID_GB;
            3'd3:    return MODE_ISLAND;
            3'd4:    return MODE_ISL_GB;
            default: return MODE_CTRL;
        endcase
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // XOR/XNOR chain; qm[8] records which one was used (1 = XOR)
    function automatic logic [QM_W-1:0] qm_encode(input logic [7:0] d);
        logic [3:0]      n;
        logic            use_xnor;
        logic [QM_W-1:0] q;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int k = 1; k < 8; k++) begin
            q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [SYM_W-1:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_SYM_00;
            2'b01:   return CTRL_SYM_01;
            2'b10:   return CTRL_SYM_10;
            default: return CTRL_SYM_11;
        endcase
    endfunction

endpackage

// File: rtl/tmds_channel_hdmi.sv
// One TMDS lane: transition-minimising stage, optional pipeline register, then
// period-dependent symbol selection with running DC-balance bias.
module tmds_channel_hdmi
    import tmds_pkg::*;
#(
    parameter int unsigned CHAN_IDX = 0,
    parameter int unsigned PIPE     = 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [2:0]       mode_i,
    input  logic [7:0]       data_i,
    input  logic [1:0]       ctrl_i,
    input  logic [3:0]       terc4_i,
    output logic [SYM_W-1:0] sym_o
);

    localparam tmds_stage_t STAGE_RST = '{
        mode:    MODE_CTRL,
        qm:      '0,
        balance: '0,
        ctrl:    2'b00,
        terc4:   4'h0
    };

    tmds_stage_t              a_d;
    tmds_stage_t              a_q;
    tmds_stage_t              b_in;
    logic [SYM_W-1:0]         sym_d;
    logic [SYM_W-1:0]         sym_q;
    logic signed [BIAS_W-1:0] bias_d;
    logic signed [BIAS_W-1:0] bias_q;

    always_comb begin
        a_d         = STAGE_RST;
        a_d.mode    = mode_decode(mode_i);
        a_d.qm      = qm_encode(data_i);
        a_d.balance = $signed({ones8(a_d.qm[7:0]), 1'b0}) - 5'sd8;
        a_d.ctrl    = ctrl_i;
        a_d.terc4   = terc4_i;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            a_q <= STAGE_RST;
        end else begin
            a_q <= a_d;
        end
    end

    if (PIPE != 0) begin : g_pipe
        tmds_stage_t p_q;

        always_ff @(posedge clk_pix or negedge rst_pix_n) begin
            if (!rst_pix_n) begin
                p_q <= STAGE_RST;
            end else begin
                p_q <= a_q;
            end
        end

        assign b_in = p_q;
    end else begin : g_nopipe
        assign b_in = a_q;
    end

    // Every non-video period leaves bias at zero via the default
    always_comb begin
        sym_d  = CTRL_SYM_00;
        bias_d = '0;
        case (b_in.mode)
            MODE_VIDEO: begin
                if ((bias_q == '0) || (b_in.balance == '0)) begin
                    if (!b_in.qm[8]) begin
                        sym_d  = {2'b10, ~b_in.qm[7:0]};
                        bias_d = bias_q - b_in.balance;
                    end else begin
                        sym_d  = {2'b01, b_in.qm[7:0]};
                        bias_d = bias_q + b_in.balance;
                    end
                end else if (bias_q[BIAS_W-1] == b_in.balance[BIAS_W-1]) begin
                    sym_d  = {1'b1, b_in.qm[8], ~b_in.qm[7:0]};
                    bias_d = bias_q + $signed({3'b000, b_in.qm[8], 1'b0}) - b_in.balance;
                end else begin
                    sym_d  = {1'b0, b_in.qm[8], b_in.qm[7:0]};
                    bias_d = bias_q + b_in.balance - $signed({3'b000, ~b_in.qm[8], 1'b0});
                end
            end
            MODE_VID_GB: sym_d = ((CHAN_IDX % 2) == 0) ? GB_SYM_EVEN : GB_SYM_ODD;
            MODE_ISLAND: sym_d = TERC4_TAB[b_in.terc4];
            MODE_ISL_GB: sym_d = (CHAN_IDX == 0) ? TERC4_TAB[b_in.terc4] : GB_SYM_ODD;
            default:     sym_d = ctrl_sym(b_in.ctrl);
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sym_q  <= CTRL_SYM_00;
            bias_q <= '0;
        end else begin
            sym_q  <= sym_d;
            bias_q <= bias_d;
        end
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// HDMI TMDS encoder top: slices the packed buses into CH independent lanes
// that share only the period mode.
module tmds_encoder_hdmi
    import tmds_pkg::*;
#(
    parameter int unsigned CH   = 3,
    parameter int unsigned PIPE = 1
) (
    input  logic                clk_pix,
    input  logic                rst_pix_n,
    input  logic [2:0]          mode,
    input  logic [CH*8-1:0]     data_in,
    input  logic [CH*2-1:0]     ctrl_in,
    input  logic [CH*4-1:0]     terc4_in,
    output logic [CH*SYM_W-1:0] tmds
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        tmds_channel_hdmi #(
            .CHAN_IDX (i),
            .PIPE     (PIPE)
        ) u_ch (
            .clk_pix   (clk_pix),
            .rst_pix_n (rst_pix_n),
            .mode_i    (mode),
            .data_i    (data_in[i*8 +: 8]),
            .ctrl_i    (ctrl_in[i*2 +: 2]),
            .terc4_i   (terc4_in[i*4 +: 4]),
            .sym_o     (tmds[i*SYM_W +: SYM_W])
        );
    end

endmodule
